pipeline_ctrl: RTL and testbench

//  Hazard/stall sequencer for the 5-stage pipeline. Drives enables and flushes of the
//  IF/DC, DC/EX, EX/MEM and MEM/WB registers plus PC enable.

---
 rtl/pipeline_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: register enables, flushes, PC enable, halt and dmem watchdog.
// Optional performance counters are built only when PIPECTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int DWAIT_MAX = 64,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             ex_load,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       dc_rs,
  input  logic [4:0]       dc_rt,
  input  logic             ex_branch_tkn,
  input  logic             dc_jump,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             pipe1_en,
  output logic             pipe2_en,
  output logic             pipe3_en,
  output logic             pipe4_en,
  output logic             flush1,
  output logic             flush2,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int WCW = $clog2(DWAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_MAX_C = WCW'(DWAIT_MAX);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_inc;
  logic           r_mem_timeout;
  logic           w_dstall;
  logic           w_load_use;

  assign w_dstall   = (r_state != ST_HALTED) && mem_req && !dhit;
  assign w_load_use = ex_load && (ex_rt != 5'd0) && ((ex_rt == dc_rs) || (ex_rt == dc_rt));
  assign w_wait_inc = (r_wait_cnt == WAIT_MAX_C) ? r_wait_cnt : r_wait_cnt + WCW'(1);

  // A flushed register keeps its enable high so the zeroed instruction is loaded.
  always_comb begin
    w_state_nxt = r_state;
    pc_en       = 1'b1;
    pipe1_en    = 1'b1;
    pipe2_en    = 1'b1;
    pipe3_en    = 1'b1;
    pipe4_en    = 1'b1;
    flush1      = 1'b0;
    flush2      = 1'b0;
    if (r_state == ST_HALTED) begin
      pc_en    = 1'b0;
      pipe1_en = 1'b0;
      pipe2_en = 1'b0;
      pipe3_en = 1'b0;
      pipe4_en = 1'b0;
    end else begin
      if (wb_halt)       w_state_nxt = ST_HALTED;
      else if (w_dstall) w_state_nxt = ST_DWAIT;
      else               w_state_nxt = ST_RUN;

      if (w_dstall) begin
        pc_en    = 1'b0;
        pipe1_en = 1'b0;
        pipe2_en = 1'b0;
        pipe3_en = 1'b0;
        pipe4_en = 1'b0;
      end else if (w_load_use) begin
        pc_en    = 1'b0;
        pipe1_en = 1'b0;
        flush2   = 1'b1;
      end else if (ex_branch_tkn) begin
        flush1 = 1'b1;
        flush2 = 1'b1;
      end else if (dc_jump) begin
        flush1 = 1'b1;
      end else if (!ihit) begin
        pc_en  = 1'b0;
        flush1 = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter saturates; the watchdog flag stays set until reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else if (r_state != ST_HALTED) begin
      if (w_dstall) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == WAIT_MAX_C) r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign halt        = (r_state == ST_HALTED);
  assign mem_timeout = r_mem_timeout;
  assign state_dbg   = r_state;

`ifdef PIPECTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_state != ST_HALTED)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush1 || flush2)                 r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed multi-cycle sequences, randomized run vs reference model.
module tb_pipeline_ctrl;

  localparam int DWAIT_MAX = 64;
  localparam int CNT_W     = 32;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_req, ex_load, ex_branch_tkn, dc_jump, wb_halt;
  logic [4:0]       ex_rt, dc_rs, dc_rt;
  logic             pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en, flush1, flush2, halt, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0]       state_dbg;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.DWAIT_MAX(DWAIT_MAX), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .ex_load(ex_load), .ex_rt(ex_rt), .dc_rs(dc_rs), .dc_rt(dc_rt),
    .ex_branch_tkn(ex_branch_tkn), .dc_jump(dc_jump), .wb_halt(wb_halt),
    .pc_en(pc_en), .pipe1_en(pipe1_en), .pipe2_en(pipe2_en), .pipe3_en(pipe3_en),
    .pipe4_en(pipe4_en), .flush1(flush1), .flush2(flush2), .halt(halt),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic       ihit, dhit, mem_req, ex_load;
    logic [4:0] ex_rt, dc_rs, dc_rt;
    logic       br, jmp, wbh;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
    logic [7:0] care;
  } vec_t;

  // Output vector bit order: pc_en, pipe1..4_en, flush1, flush2, halt
  localparam logic [7:0] O_RUN   = 8'b11111000, C_ALL   = 8'hFF;
  localparam logic [7:0] O_STALL = 8'b00000000, O_HALT  = 8'b00000001;
  localparam logic [7:0] O_LU    = 8'b00011010, C_LU    = 8'b11011111;
  localparam logic [7:0] O_BR    = 8'b10011110, C_BR    = 8'b10011111;
  localparam logic [7:0] O_JMP   = 8'b10111100, C_JMP   = 8'b10111111;
  localparam logic [7:0] O_IMISS = 8'b00111100, C_IMISS = 8'b10111111;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  // Reference model state
  bit               m_halted, m_dwait, m_timeout;
  int               m_wait;
  logic [CNT_W-1:0] m_stall, m_flush;

  function automatic in_t mk(input logic ih, input logic dh, input logic mr, input logic ld,
                             input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] drt,
                             input logic br, input logic jp, input logic wh);
    in_t v;
    v.ihit = ih; v.dhit = dh; v.mem_req = mr; v.ex_load = ld;
    v.ex_rt = rt; v.dc_rs = rs; v.dc_rt = drt; v.br = br; v.jmp = jp; v.wbh = wh;
    return v;
  endfunction

  function automatic logic [7:0] dut_vec();
    return {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en, flush1, flush2, halt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Spec priority list: halted > dmem stall > load-use > branch > jump > imem miss > run.
  function automatic void model_out(input in_t v, output logic [7:0] e, output logic [7:0] c);
    bit dst, lu;
    dst = v.mem_req && !v.dhit;
    lu  = v.ex_load && (v.ex_rt != 0) && ((v.ex_rt == v.dc_rs) || (v.ex_rt == v.dc_rt));
    if (m_halted)   begin e = O_HALT;  c = C_ALL;   end
    else if (dst)   begin e = O_STALL; c = C_ALL;   end
    else if (lu)    begin e = O_LU;    c = C_LU;    end
    else if (v.br)  begin e = O_BR;    c = C_BR;    end
    else if (v.jmp) begin e = O_JMP;   c = C_JMP;   end
    else if (!v.ihit) begin e = O_IMISS; c = C_IMISS; end
    else            begin e = O_RUN;   c = C_ALL;   end
  endfunction

  function automatic logic [1:0] model_state();
    if (m_halted) return 2'd2;
    return m_dwait ? 2'd1 : 2'd0;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_dwait = 0; m_timeout = 0; m_wait = 0; m_stall = '0; m_flush = '0;
  endtask

  task automatic model_step(input in_t v);
    logic [7:0] e, c;
    bit dst;
    if (m_halted) return;
    model_out(v, e, c);
    if (!e[7]) m_stall = m_stall + 1;
    if (e[2] || e[1]) m_flush = m_flush + 1;
    dst = v.mem_req && !v.dhit;
    if (dst) begin
      if (m_wait < DWAIT_MAX) m_wait = m_wait + 1;
      if (m_wait == DWAIT_MAX) m_timeout = 1;
      m_dwait = 1;
    end else begin
      m_wait = 0;
      m_dwait = 0;
    end
    if (v.wbh) m_halted = 1;
  endtask

  task automatic set_inputs(input in_t v);
    ihit = v.ihit; dhit = v.dhit; mem_req = v.mem_req; ex_load = v.ex_load;
    ex_rt = v.ex_rt; dc_rs = v.dc_rs; dc_rt = v.dc_rt;
    ex_branch_tkn = v.br; dc_jump = v.jmp; wb_halt = v.wbh;
  endtask

  task automatic check_counters();
`ifdef PIPECTRL_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
    check("stall_cnt", 64'(stall_cnt), 64'd0);
    check("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input in_t v, output logic [7:0] act);
    logic [7:0] e, c;
    logic [15:0] item;
    set_inputs(v);
    #4;
    model_out(v, e, c);
    exp_q.push_back({c, e});
    item = exp_q.pop_front();
    act = dut_vec();
    check("outs", 64'(act & item[15:8]), 64'(item[7:0] & item[15:8]));
    check("state", 64'(state_dbg), 64'(model_state()));
    check("mem_timeout", 64'(mem_timeout), 64'(m_timeout));
    check_counters();
    @(posedge CLK);
    #1;
    model_step(v);
  endtask

  task automatic do_reset();
    set_inputs(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    nRST = 1'b0;
    model_reset();
    #3;
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_outs", 64'(dut_vec()), 64'(O_RUN));
    check("rst_timeout", 64'(mem_timeout), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  vec_t tbl[14];
  logic [7:0] act;
  logic [CNT_W-1:0] c0;
  in_t idle, stall;
  int halted_cycles;

  initial begin
    idle  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{mk(1,0,0,0, 0,0,0, 0,0,0), O_RUN,   C_ALL};
    tbl[1]  = '{mk(1,0,0,1, 5,5,3, 0,0,0), O_LU,    C_LU};
    tbl[2]  = '{mk(1,0,0,1, 7,1,7, 0,0,0), O_LU,    C_LU};
    tbl[3]  = '{mk(1,0,0,1, 0,0,0, 0,0,0), O_RUN,   C_ALL};
    tbl[4]  = '{mk(1,0,0,0, 5,5,5, 0,0,0), O_RUN,   C_ALL};
    tbl[5]  = '{mk(1,0,0,1, 5,6,4, 0,0,0), O_RUN,   C_ALL};
    tbl[6]  = '{mk(1,0,0,0, 0,0,0, 1,1,0), O_BR,    C_BR};
    tbl[7]  = '{mk(1,0,0,0, 0,0,0, 0,1,0), O_JMP,   C_JMP};
    tbl[8]  = '{mk(0,0,0,0, 0,0,0, 0,0,0), O_IMISS, C_IMISS};
    tbl[9]  = '{mk(0,0,0,0, 0,0,0, 0,1,0), O_JMP,   C_JMP};
    tbl[10] = '{mk(1,0,0,1, 9,9,2, 1,0,0), O_LU,    C_LU};
    tbl[11] = '{mk(1,1,1,0, 0,0,0, 1,0,0), O_BR,    C_BR};
    tbl[12] = '{mk(1,0,1,0, 0,0,0, 1,1,0), O_STALL, C_ALL};
    tbl[13] = '{mk(1,1,1,0, 0,0,0, 0,0,0), O_RUN,   C_ALL};

    do_reset();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].in, act);
      check($sformatf("tbl%0d", i), 64'(act & tbl[i].care), 64'(tbl[i].exp & tbl[i].care));
    end

    // dmem stall for 3 cycles, then dhit
    do_reset();
    c0 = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      cycle(stall, act);
      check("dstall_en", 64'(act), 64'(O_STALL));
      check("dstall_state", 64'(state_dbg), 64'd1);
    end
    cycle(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), act);
    check("dhit_en", 64'(act), 64'(O_RUN));
    check("dhit_state", 64'(state_dbg), 64'd0);
`ifdef PIPECTRL_PERF_EN
    check("stall_delta", 64'(stall_cnt - c0), 64'd3);
`else
    check("stall_delta", 64'(stall_cnt - c0), 64'd0);
`endif

    // Branch flush counted once
    c0 = flush_cnt;
    cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), act);
    cycle(idle, act);
`ifdef PIPECTRL_PERF_EN
    check("flush_delta", 64'(flush_cnt - c0), 64'd1);
`else
    check("flush_delta", 64'(flush_cnt - c0), 64'd0);
`endif

    // Watchdog boundary
    do_reset();
    for (int i = 0; i < DWAIT_MAX - 1; i++) cycle(stall, act);
    check("timeout_before", 64'(mem_timeout), 64'd0);
    cycle(stall, act);
    check("timeout_at_max", 64'(mem_timeout), 64'd1);
    cycle(stall, act);
    check("timeout_stall_persists", 64'(act), 64'(O_STALL));
    cycle(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), act);
    cycle(idle, act);
    check("timeout_sticky", 64'(mem_timeout), 64'd1);

    // HALT arriving together with a dmem stall
    do_reset();
    cycle(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1), act);
    check("halt_set", 64'(halt), 64'd1);
    check("halt_state", 64'(state_dbg), 64'd2);
    for (int i = 0; i < 8; i++) begin
      cycle(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               0, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0), act);
      check("halt_outs", 64'(act), 64'(O_HALT));
    end

    // Reset asserted mid-DWAIT
    do_reset();
    cycle(stall, act);
    cycle(stall, act);
    check("dwait_before_rst", 64'(state_dbg), 64'd1);
    nRST = 1'b0;
    model_reset();
    #2;
    check("async_rst_state", 64'(state_dbg), 64'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cycle(idle, act);
    check("after_rst_en", 64'(act), 64'(O_RUN));

    // Randomized run against the reference model
    do_reset();
    halted_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      in_t v;
      v.ihit    = ($urandom_range(0, 9) < 8);
      v.dhit    = $urandom_range(0, 1);
      v.mem_req = ($urandom_range(0, 9) < 4);
      v.ex_load = ($urandom_range(0, 9) < 3);
      v.ex_rt   = 5'($urandom_range(0, 3));
      v.dc_rs   = 5'($urandom_range(0, 3));
      v.dc_rt   = 5'($urandom_range(0, 3));
      v.br      = ($urandom_range(0, 99) < 15);
      v.jmp     = ($urandom_range(0, 99) < 15);
      v.wbh     = ($urandom_range(0, 149) == 0);
      cycle(v, act);
      if (m_halted) halted_cycles++;
      if (halted_cycles >= 5) begin
        halted_cycles = 0;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
